alu_wide_seq: RTL and testbench

ALU_WIDE_SEQ -- requirements
Module: alu_wide_seq

---
 rtl/wide_alu_pkg.sv | 19 +
 rtl/wide_alu_core.sv | 47 ++++
 rtl/alu_wide_seq.sv | 153 +++++++++++++++
 tb/tb_alu_wide_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_alu_pkg.sv
// Shared types and constants for the sequential double-width ALU wrapper
// and the single-width ALU it drives.
package wide_alu_pkg;

   localparam int N_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RSP  = 2'd3
   } state_e;

   // Op codes packed as {S[3:0], M}
   localparam logic [4:0] ALU_ADD = {4'b1001, 1'b0};
   localparam logic [4:0] ALU_SUB = {4'b0110, 1'b0};
   localparam logic [4:0] ALU_XOR = {4'b0110, 1'b1};

endpackage

// File: rtl/wide_alu_core.sv
// Single-width combinational ALU: arithmetic (M=0) with carry in/out,
// bitwise logic (M=1) with carry and overflow forced low.
module wide_alu_core
   import wide_alu_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   s,
   input  logic         m,
   input  logic         cin,
   output logic [N-1:0] y,
   output logic         c,
   output logic         v,
   output logic         n,
   output logic         z
);

   logic [N:0]   sum;
   logic [N-1:0] bb;

   always_comb begin
      bb  = '0;
      sum = '0;
      y   = '0;
      c   = 1'b0;
      v   = 1'b0;
      if (!m) begin
         if (s == ALU_ADD[4:1]) bb = b;
         else if (s == ALU_SUB[4:1]) bb = ~b;
         else bb = '0;
         sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, cin};
         y   = sum[N-1:0];
         c   = sum[N];
         v   = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
      end else begin
         if (s == ALU_XOR[4:1]) y = a ^ b;
         else if (s == 4'b1011) y = a & b;
         else if (s == 4'b1110) y = a | b;
         else y = a;
      end
      n = y[N-1];
      z = (y == '0);
   end

endmodule

// File: rtl/alu_wide_seq.sv
// Runs a 2N-bit ALU operation as two N-bit beats (low then high) through
// an external N-bit ALU, with valid/ready request and response handshakes.
module alu_wide_seq
   import wide_alu_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [2*N-1:0] req_a,
   input  logic [2*N-1:0] req_b,
   input  logic [3:0]     req_s,
   input  logic           req_m,
   input  logic           req_cin,
   output logic [N-1:0]   alu_opA,
   output logic [N-1:0]   alu_opB,
   output logic [3:0]     alu_S,
   output logic           alu_M,
   output logic           alu_Cin,
   input  logic [N-1:0]   alu_DO,
   input  logic           alu_C,
   input  logic           alu_V,
   input  logic           alu_N,
   input  logic           alu_Z,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [2*N-1:0] rsp_do,
   output logic           rsp_c,
   output logic           rsp_v,
   output logic           rsp_n,
   output logic           rsp_z,
   output logic           busy
);

   state_e         state_q, state_d;
   logic [2*N-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]     s_q, s_d;
   logic           m_q, m_d, cin_q, cin_d;
   logic [N-1:0]   lo_do_q, lo_do_d, hi_do_q, hi_do_d;
   logic           lo_c_q, lo_c_d, lo_z_q, lo_z_d;
   logic           hi_c_q, hi_c_d, hi_v_q, hi_v_d;
   logic           hi_n_q, hi_n_d, hi_z_q, hi_z_d;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      m_d       = m_q;
      cin_d     = cin_q;
      lo_do_d   = lo_do_q;
      lo_c_d    = lo_c_q;
      lo_z_d    = lo_z_q;
      hi_do_d   = hi_do_q;
      hi_c_d    = hi_c_q;
      hi_v_d    = hi_v_q;
      hi_n_d    = hi_n_q;
      hi_z_d    = hi_z_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_opA   = '0;
      alu_opB   = '0;
      alu_S     = '0;
      alu_M     = 1'b0;
      alu_Cin   = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               s_d     = req_s;
               m_d     = req_m;
               cin_d   = req_cin;
               state_d = LO;
            end
         end
         LO: begin
            alu_opA = a_q[N-1:0];
            alu_opB = b_q[N-1:0];
            alu_S   = s_q;
            alu_M   = m_q;
            alu_Cin = cin_q;
            lo_do_d = alu_DO;
            lo_c_d  = alu_C;
            lo_z_d  = alu_Z;
            state_d = HI;
         end
         HI: begin
            alu_opA = a_q[2*N-1:N];
            alu_opB = b_q[2*N-1:N];
            alu_S   = s_q;
            alu_M   = m_q;
            // Logic ops have no carry chain between beats
            alu_Cin = m_q ? cin_q : lo_c_q;
            hi_do_d = alu_DO;
            hi_c_d  = alu_C;
            hi_v_d  = alu_V;
            hi_n_d  = alu_N;
            hi_z_d  = alu_Z;
            state_d = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         m_q     <= 1'b0;
         cin_q   <= 1'b0;
         lo_do_q <= '0;
         lo_c_q  <= 1'b0;
         lo_z_q  <= 1'b0;
         hi_do_q <= '0;
         hi_c_q  <= 1'b0;
         hi_v_q  <= 1'b0;
         hi_n_q  <= 1'b0;
         hi_z_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         m_q     <= m_d;
         cin_q   <= cin_d;
         lo_do_q <= lo_do_d;
         lo_c_q  <= lo_c_d;
         lo_z_q  <= lo_z_d;
         hi_do_q <= hi_do_d;
         hi_c_q  <= hi_c_d;
         hi_v_q  <= hi_v_d;
         hi_n_q  <= hi_n_d;
         hi_z_q  <= hi_z_d;
      end
   end

   assign rsp_do = {hi_do_q, lo_do_q};
   assign rsp_c  = hi_c_q;
   assign rsp_v  = hi_v_q;
   assign rsp_n  = hi_n_q;
   assign rsp_z  = lo_z_q & hi_z_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq with a 32-bit ALU attached; results are compared
// against plain 64-bit arithmetic on the whole operands.
module tb_alu_wide_seq;
   import wide_alu_pkg::*;

   localparam int N = 32;
   localparam int W = 2 * N;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready;
   logic [W-1:0] req_a, req_b;
   logic [3:0]   req_s;
   logic         req_m, req_cin;
   logic [N-1:0] alu_opA, alu_opB, alu_DO;
   logic [3:0]   alu_S;
   logic         alu_M, alu_Cin, alu_C, alu_V, alu_N, alu_Z;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_do;
   logic         rsp_c, rsp_v, rsp_n, rsp_z, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_wide_seq #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_s(req_s),
      .req_m(req_m), .req_cin(req_cin),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S),
      .alu_M(alu_M), .alu_Cin(alu_Cin),
      .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V),
      .alu_N(alu_N), .alu_Z(alu_Z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_do(rsp_do), .rsp_c(rsp_c), .rsp_v(rsp_v),
      .rsp_n(rsp_n), .rsp_z(rsp_z), .busy(busy)
   );

   wide_alu_core #(.N(N)) u_alu (
      .a(alu_opA), .b(alu_opB), .s(alu_S), .m(alu_M), .cin(alu_Cin),
      .y(alu_DO), .c(alu_C), .v(alu_V), .n(alu_N), .z(alu_Z)
   );

   // Returns {c, v, n, z, result} for the whole 64-bit operation
   function automatic logic [W+3:0] ref_op(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [4:0] sm,
                                           input logic cin);
      logic [W:0]   sum;
      logic [W-1:0] res, bb;
      logic         c, v;
      sum = '0;
      bb  = b;
      c   = 1'b0;
      v   = 1'b0;
      if (sm == ALU_XOR) begin
         res = a ^ b;
      end else begin
         if (sm == ALU_SUB) bb = ~b;
         sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
         res = sum[W-1:0];
         c   = sum[W];
         v   = (a[W-1] == bb[W-1]) && (res[W-1] != a[W-1]);
      end
      return {c, v, res[W-1], (res == '0), res};
   endfunction

   task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sm, input logic cin,
                          output logic [W-1:0] o_do,
                          output logic [3:0] o_cvnz,
                          output int lat, output logic hi_cin);
      int w;
      w = 0;
      @(negedge clk);
      req_a = a; req_b = b; req_s = sm[4:1]; req_m = sm[0];
      req_cin = cin; req_valid = 1'b1;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_s = 4'($urandom);
      req_m = 1'($urandom);
      req_cin = 1'($urandom);
      lat = 0;
      hi_cin = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 2) hi_cin = alu_Cin;
      end while (!rsp_valid && lat < 10);
      req_valid = 1'b0;
      o_do = rsp_do;
      o_cvnz = {rsp_c, rsp_v, rsp_n, rsp_z};
   endtask

   task automatic finish_rsp();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cin = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({req_ready, busy, rsp_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_ctl rdy/busy/vld=%b required 100",
                  {req_ready, busy, rsp_valid});
      end
      n_checks++;
      if ({rsp_do, rsp_c, rsp_v, rsp_n, rsp_z} !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp do=%h cvnz=%b required 0", rsp_do,
                  {rsp_c, rsp_v, rsp_n, rsp_z});
      end
      n_checks++;
      if ({alu_opA, alu_opB, alu_S, alu_M, alu_Cin} !== '0) begin
         n_fail++;
         $display("FAIL reset_alu_drive opA=%h opB=%h required 0",
                  alu_opA, alu_opB);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({req_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release rdy/busy=%b required 10",
                  {req_ready, busy});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] d;
      logic [3:0]   f;
      int           lat;
      logic         hc;
      run_req(64'h0000_0000_FFFF_FFFF, 64'h1, ALU_ADD, 1'b0, d, f, lat, hc);
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL add_carry_latency got %0d required 3", lat);
      end
      n_checks++;
      if (d !== 64'h0000_0001_0000_0000 || f[3] !== 1'b0 || f[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL add_carry do=%h c=%b z=%b required 0000000100000000 0 0",
                  d, f[3], f[0]);
      end
      finish_rsp();
      run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD, 1'b0, d, f, lat, hc);
      n_checks++;
      if (d !== 64'h0 || f[3] !== 1'b1 || f[0] !== 1'b1 || f[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL add_wrap do=%h c=%b z=%b v=%b required 0 1 1 0",
                  d, f[3], f[0], f[2]);
      end
      finish_rsp();
      run_req(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD, 1'b0, d, f, lat, hc);
      n_checks++;
      if (d !== 64'h8000_0000_0000_0000 || f[2] !== 1'b1 || f[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL add_ovf do=%h v=%b n=%b required 8000000000000000 1 1",
                  d, f[2], f[1]);
      end
      finish_rsp();
      run_req(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, ALU_XOR, 1'b1,
              d, f, lat, hc);
      n_checks++;
      if (d !== 64'h0000_0000_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL xor_do got %h required 00000000ffffffff", d);
      end
      n_checks++;
      if (hc !== 1'b1) begin
         n_fail++;
         $display("FAIL xor_hi_cin got %b required 1", hc);
      end
      finish_rsp();
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, d;
      logic [4:0]   sm;
      logic         cin, hc;
      logic [3:0]   f;
      logic [W+3:0] exp;
      int           lat, k;
      for (int i = 0; i < 40; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (i % 5 == 0) b = ~a;
         k = $urandom_range(0, 2);
         sm = (k == 0) ? ALU_ADD : (k == 1) ? ALU_SUB : ALU_XOR;
         cin = 1'($urandom);
         exp = ref_op(a, b, sm, cin);
         run_req(a, b, sm, cin, d, f, lat, hc);
         n_checks++;
         if (lat !== 3 || d !== exp[W-1:0] || f !== exp[W+3:W]) begin
            n_fail++;
            $display("FAIL rand_%0d lat=%0d do=%h cvnz=%b required 3 %h %b",
                     i, lat, d, f, exp[W-1:0], exp[W+3:W]);
         end
         n_checks++;
         if ({alu_opA, alu_opB, alu_S, alu_M, alu_Cin} !== '0) begin
            n_fail++;
            $display("FAIL rand_rsp_alu_idle_%0d opA=%h opB=%h required 0",
                     i, alu_opA, alu_opB);
         end
         finish_rsp();
         n_checks++;
         if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL rand_return_%0d vld/rdy/busy=%b required 010",
                     i, {rsp_valid, req_ready, busy});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d, snap, a2, b2;
      logic [3:0]   f;
      logic [W+3:0] exp2;
      int           lat;
      logic         hc;
      a2 = {$urandom, $urandom};
      b2 = {$urandom, $urandom};
      exp2 = ref_op(a2, b2, ALU_SUB, 1'b1);
      run_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, ALU_ADD, 1'b0,
              d, f, lat, hc);
      snap = rsp_do;
      req_a = a2; req_b = b2; req_s = ALU_SUB[4:1]; req_m = ALU_SUB[0];
      req_cin = 1'b1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_do !== snap
             || rsp_do !== 64'h2222_2222_2222_2211) begin
            n_fail++;
            $display("FAIL hold_%0d vld=%b rdy=%b do=%h required 1 0 %h",
                     i, rsp_valid, req_ready, rsp_do, 64'h2222_2222_2222_2211);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL release_idle rdy/vld/busy=%b required 100",
                  {req_ready, rsp_valid, busy});
      end
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if ({busy, req_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL next_accept busy/rdy=%b required 10", {busy, req_ready});
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_do !== exp2[W-1:0]
          || {rsp_c, rsp_v, rsp_n, rsp_z} !== exp2[W+3:W]) begin
         n_fail++;
         $display("FAIL second_op vld=%b do=%h required 1 %h",
                  rsp_valid, rsp_do, exp2[W-1:0]);
      end
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_b = 64'h3;
      req_s = ALU_ADD[4:1]; req_m = ALU_ADD[0]; req_cin = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy got %b required 1", busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({req_ready, busy, rsp_valid} !== 3'b100
          || {rsp_do, rsp_c, rsp_v, rsp_n, rsp_z} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset rdy/busy/vld=%b do=%h required 100 0",
                  {req_ready, busy, rsp_valid}, rsp_do);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_rsp_%0d vld=%b busy=%b required 0 0",
                     i, rsp_valid, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
